// File: rtl/banco_registradores_param_if.sv
// Bus bundle for the parametrised register file: read, write and reservation ports.
interface banco_registradores_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic              LeReg;
  logic [ADDR_W-1:0] RegLido1;
  logic [ADDR_W-1:0] RegLido2;
  logic              EscReg;
  logic [ADDR_W-1:0] RegEscrito;
  logic [DATA_W-1:0] DadoEscrito;
  logic              Reserva;
  logic [ADDR_W-1:0] RegReservado;
  logic [DATA_W-1:0] DadoLido1;
  logic [DATA_W-1:0] DadoLido2;
  logic [DATA_W-1:0] DadoDedicado;
  logic              Pend1;
  logic              Pend2;

  modport master (
    output LeReg, RegLido1, RegLido2, EscReg, RegEscrito, DadoEscrito,
           Reserva, RegReservado,
    input  DadoLido1, DadoLido2, DadoDedicado, Pend1, Pend2
  );

  modport slave (
    input  LeReg, RegLido1, RegLido2, EscReg, RegEscrito, DadoEscrito,
           Reserva, RegReservado,
    output DadoLido1, DadoLido2, DadoDedicado, Pend1, Pend2
  );
endinterface

// File: rtl/banco_registradores_param.sv
// Parametrised register file: two registered read ports with write-first bypass,
// one write port, a dedicated monitor output and per-register pending bits.
module banco_registradores_param #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       NUM_REGS  = 8,
  parameter int unsigned       ADDR_W    = 3,
  parameter int unsigned       DEDIC_IDX = 7,
  parameter bit                ZERO_REG  = 1'b0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic                        clock,
  input logic                        reset,
  banco_registradores_param_if.slave bus
);
  localparam logic [ADDR_W-1:0] DEDIC_ADDR = ADDR_W'(DEDIC_IDX);
  localparam logic [DATA_W-1:0] DEDIC_RST  = (ZERO_REG && (DEDIC_IDX == 0)) ? '0 : RESET_VAL;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_nxt;
  logic [DATA_W-1:0]   rd1;
  logic [DATA_W-1:0]   rd2;
  logic [DATA_W-1:0]   ded;
  logic [DATA_W-1:0]   rd1_nxt;
  logic [DATA_W-1:0]   rd2_nxt;
  logic [DATA_W-1:0]   ded_nxt;
  logic                wr_ok;
  logic                rs_ok;

  // An address is usable when in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
  endfunction

  assign wr_ok = bus.EscReg  && addr_ok(bus.RegEscrito);
  assign rs_ok = bus.Reserva && addr_ok(bus.RegReservado);

  // Read values with write-first bypass; unusable addresses read zero.
  always_comb begin
    rd1_nxt = '0;
    rd2_nxt = '0;
    ded_nxt = '0;
    if (addr_ok(bus.RegLido1))
      rd1_nxt = (wr_ok && (bus.RegEscrito == bus.RegLido1)) ? bus.DadoEscrito : regs[bus.RegLido1];
    if (addr_ok(bus.RegLido2))
      rd2_nxt = (wr_ok && (bus.RegEscrito == bus.RegLido2)) ? bus.DadoEscrito : regs[bus.RegLido2];
    if (addr_ok(DEDIC_ADDR))
      ded_nxt = (wr_ok && (bus.RegEscrito == DEDIC_ADDR)) ? bus.DadoEscrito : regs[DEDIC_ADDR];
  end

  // A new reservation supersedes a completing write to the same register.
  always_comb begin
    pend_nxt = pend;
    if (wr_ok) pend_nxt[bus.RegEscrito]   = 1'b0;
    if (rs_ok) pend_nxt[bus.RegReservado] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      pend <= '0;
      rd1  <= '0;
      rd2  <= '0;
      ded  <= DEDIC_RST;
    end else begin
      if (wr_ok) regs[bus.RegEscrito] <= bus.DadoEscrito;
      if (bus.LeReg) begin
        rd1 <= rd1_nxt;
        rd2 <= rd2_nxt;
      end
      ded  <= ded_nxt;
      pend <= pend_nxt;
    end
  end

  assign bus.DadoLido1    = rd1;
  assign bus.DadoLido2    = rd2;
  assign bus.DadoDedicado = ded;
  assign bus.Pend1        = addr_ok(bus.RegLido1) && pend[bus.RegLido1];
  assign bus.Pend2        = addr_ok(bus.RegLido2) && pend[bus.RegLido2];
endmodule

// File: tb/tb_banco_registradores_param.sv
// Bench for banco_registradores_param: three configurations share one stimulus stream
// and are checked against an array-based reference model plus directed constants.
module tb_banco_registradores_param;
  // cfg0: defaults; cfg1: 8-bit, 6 regs, zero reg, a0=R0, reset 0x5A; cfg2: 16x16, a0=R15
  localparam int unsigned DW [3] = '{8, 8, 16};
  localparam int unsigned AW [3] = '{3, 3, 4};
  localparam int unsigned NR [3] = '{8, 6, 16};
  localparam int unsigned DI [3] = '{7, 0, 15};
  localparam bit          ZR [3] = '{1'b0, 1'b1, 1'b0};
  localparam logic [15:0] RV [3] = '{16'h0000, 16'h005A, 16'h0000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_le, s_we, s_res;
  logic [3:0]  s_ra1, s_ra2, s_wa, s_rr;
  logic [15:0] s_wd;

  banco_registradores_param_if #(.DATA_W(8),  .ADDR_W(3)) bus_a ();
  banco_registradores_param_if #(.DATA_W(8),  .ADDR_W(3)) bus_b ();
  banco_registradores_param_if #(.DATA_W(16), .ADDR_W(4)) bus_c ();

  assign bus_a.LeReg = s_le;  assign bus_a.EscReg = s_we;  assign bus_a.Reserva = s_res;
  assign bus_a.RegLido1 = s_ra1[2:0]; assign bus_a.RegLido2 = s_ra2[2:0];
  assign bus_a.RegEscrito = s_wa[2:0]; assign bus_a.RegReservado = s_rr[2:0];
  assign bus_a.DadoEscrito = s_wd[7:0];
  assign bus_b.LeReg = s_le;  assign bus_b.EscReg = s_we;  assign bus_b.Reserva = s_res;
  assign bus_b.RegLido1 = s_ra1[2:0]; assign bus_b.RegLido2 = s_ra2[2:0];
  assign bus_b.RegEscrito = s_wa[2:0]; assign bus_b.RegReservado = s_rr[2:0];
  assign bus_b.DadoEscrito = s_wd[7:0];
  assign bus_c.LeReg = s_le;  assign bus_c.EscReg = s_we;  assign bus_c.Reserva = s_res;
  assign bus_c.RegLido1 = s_ra1; assign bus_c.RegLido2 = s_ra2;
  assign bus_c.RegEscrito = s_wa; assign bus_c.RegReservado = s_rr;
  assign bus_c.DadoEscrito = s_wd;

  banco_registradores_param dut_a (.clock(clk), .reset(rst), .bus(bus_a));
  banco_registradores_param #(.DATA_W(8), .NUM_REGS(6), .ADDR_W(3), .DEDIC_IDX(0),
                              .ZERO_REG(1'b1), .RESET_VAL(8'h5A))
    dut_b (.clock(clk), .reset(rst), .bus(bus_b));
  banco_registradores_param #(.DATA_W(16), .NUM_REGS(16), .ADDR_W(4), .DEDIC_IDX(15))
    dut_c (.clock(clk), .reset(rst), .bus(bus_c));

  logic [15:0] got_rd1 [3];
  logic [15:0] got_rd2 [3];
  logic [15:0] got_ded [3];
  logic        got_p1  [3];
  logic        got_p2  [3];
  assign got_rd1[0] = 16'(bus_a.DadoLido1); assign got_rd1[1] = 16'(bus_b.DadoLido1); assign got_rd1[2] = bus_c.DadoLido1;
  assign got_rd2[0] = 16'(bus_a.DadoLido2); assign got_rd2[1] = 16'(bus_b.DadoLido2); assign got_rd2[2] = bus_c.DadoLido2;
  assign got_ded[0] = 16'(bus_a.DadoDedicado); assign got_ded[1] = 16'(bus_b.DadoDedicado); assign got_ded[2] = bus_c.DadoDedicado;
  assign got_p1[0] = bus_a.Pend1; assign got_p1[1] = bus_b.Pend1; assign got_p1[2] = bus_c.Pend1;
  assign got_p2[0] = bus_a.Pend2; assign got_p2[1] = bus_b.Pend2; assign got_p2[2] = bus_c.Pend2;

  // Reference model state
  logic [15:0] m_reg  [3][16];
  bit          m_pend [3][16];
  logic [15:0] m_rd1  [3];
  logic [15:0] m_rd2  [3];
  logic [15:0] m_ded  [3];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [15:0] dmask(int k, logic [15:0] x);
    return x & 16'((32'd1 << DW[k]) - 32'd1);
  endfunction

  function automatic int unsigned amask(int k, logic [3:0] a);
    return 32'(a) & ((32'd1 << AW[k]) - 32'd1);
  endfunction

  function automatic bit valid(int k, int unsigned a);
    return (a < NR[k]) && !(ZR[k] && (a == 0));
  endfunction

  function automatic logic [15:0] m_read(int k, int unsigned a, bit wv, int unsigned wa, logic [15:0] wd);
    if (!valid(k, a)) return 16'h0;
    if (wv && (a == wa)) return wd;
    return m_reg[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 16; r++) begin
        m_reg[k][r]  = dmask(k, RV[k]);
        m_pend[k][r] = 1'b0;
      end
      m_rd1[k] = 16'h0;
      m_rd2[k] = 16'h0;
      m_ded[k] = valid(k, DI[k]) ? dmask(k, RV[k]) : 16'h0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int unsigned wa, rr, ra1, ra2;
      bit          wv, rv;
      logic [15:0] wd;
      wa  = amask(k, s_wa);  rr  = amask(k, s_rr);
      ra1 = amask(k, s_ra1); ra2 = amask(k, s_ra2);
      wd  = dmask(k, s_wd);
      wv  = s_we && valid(k, wa);
      rv  = s_res && valid(k, rr);
      if (s_le) begin
        m_rd1[k] = m_read(k, ra1, wv, wa, wd);
        m_rd2[k] = m_read(k, ra2, wv, wa, wd);
      end
      m_ded[k] = m_read(k, DI[k], wv, wa, wd);
      if (wv) begin
        m_reg[k][wa]  = wd;
        m_pend[k][wa] = 1'b0;
      end
      if (rv) m_pend[k][rr] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    #1;
  endtask

  task automatic drive(bit le, bit we, bit res, logic [3:0] ra1, logic [3:0] ra2,
                       logic [3:0] wa, logic [15:0] wd, logic [3:0] rr);
    s_le = le; s_we = we; s_res = res; s_ra1 = ra1; s_ra2 = ra2;
    s_wa = wa; s_wd = wd; s_rr = rr;
  endtask

  task automatic test_reset();
    logic [15:0] e [3];
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'd2, 4'd5, 4'd0, 16'h0, 4'd0);
    step(); step();
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_rd1[k] !== 16'h0) $display("FAIL reset_rd1 cfg%0d got=%h exp=0000", k, got_rd1[k]); else n_pass++;
      n_chk++; if (got_rd2[k] !== 16'h0) $display("FAIL reset_rd2 cfg%0d got=%h exp=0000", k, got_rd2[k]); else n_pass++;
      n_chk++; if (got_ded[k] !== 16'h0) $display("FAIL reset_ded cfg%0d got=%h exp=0000", k, got_ded[k]); else n_pass++;
      n_chk++; if ({got_p1[k], got_p2[k]} !== 2'b00) $display("FAIL reset_pend cfg%0d got=%b%b exp=00", k, got_p1[k], got_p2[k]); else n_pass++;
    end
    rst = 1'b0;
    step();
    e = '{16'h0000, 16'h005A, 16'h0000};
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_rd1[k] !== e[k]) $display("FAIL post_reset_rd1 cfg%0d got=%h exp=%h", k, got_rd1[k], e[k]); else n_pass++;
      n_chk++; if (got_rd2[k] !== e[k]) $display("FAIL post_reset_rd2 cfg%0d got=%h exp=%h", k, got_rd2[k], e[k]); else n_pass++;
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b1, 1'b0, 4'd2, 4'd5, 4'd5, 16'h002B, 4'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_rd2[k] !== 16'h002B) $display("FAIL bypass_rd2 cfg%0d got=%h exp=002b", k, got_rd2[k]); else n_pass++;
    end
    drive(1'b1, 1'b0, 1'b0, 4'd5, 4'd5, 4'd0, 16'h0, 4'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_rd1[k] !== 16'h002B) $display("FAIL stored_rd1 cfg%0d got=%h exp=002b", k, got_rd1[k]); else n_pass++;
    end
  endtask

  task automatic test_dedicated_hold();
    logic [15:0] e [3];
    drive(1'b1, 1'b1, 1'b0, 4'd5, 4'd5, 4'd7, 16'h007F, 4'd0);
    step();
    e = '{16'h007F, 16'h0000, 16'h0000};
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_ded[k] !== e[k]) $display("FAIL dedicated cfg%0d got=%h exp=%h", k, got_ded[k], e[k]); else n_pass++;
    end
    drive(1'b0, 1'b0, 1'b0, 4'd7, 4'd3, 4'd0, 16'h0, 4'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_rd1[k] !== 16'h002B) $display("FAIL hold_rd1 cfg%0d got=%h exp=002b", k, got_rd1[k]); else n_pass++;
      n_chk++; if (got_rd2[k] !== 16'h002B) $display("FAIL hold_rd2 cfg%0d got=%h exp=002b", k, got_rd2[k]); else n_pass++;
    end
  endtask

  task automatic test_zero_reg();
    logic [15:0] e [3];
    logic        p [3];
    drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd6, 4'd0, 16'h00AA, 4'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 4'd6, 4'd6, 16'h0033, 4'd0);
    step();
    e = '{16'h00AA, 16'h0000, 16'h00AA};
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_rd1[k] !== e[k]) $display("FAIL zero_reg_rd1 cfg%0d got=%h exp=%h", k, got_rd1[k], e[k]); else n_pass++;
    end
    e = '{16'h0033, 16'h0000, 16'h0033};
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_rd2[k] !== e[k]) $display("FAIL range_rd2 cfg%0d got=%h exp=%h", k, got_rd2[k], e[k]); else n_pass++;
    end
    drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd7, 4'd0, 16'h0, 4'd0);
    step();
    p = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_p1[k] !== p[k]) $display("FAIL zero_reg_pend cfg%0d got=%b exp=%b", k, got_p1[k], p[k]); else n_pass++;
    end
    drive(1'b1, 1'b0, 1'b1, 4'd0, 4'd7, 4'd0, 16'h0, 4'd7);
    step();
    s_res = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_p2[k] !== p[k]) $display("FAIL range_pend cfg%0d got=%b exp=%b", k, got_p2[k], p[k]); else n_pass++;
    end
  endtask

  task automatic test_pending();
    drive(1'b1, 1'b0, 1'b1, 4'd3, 4'd1, 4'd0, 16'h0, 4'd3);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_p1[k] !== 1'b0) $display("FAIL pend_no_bypass cfg%0d got=%b exp=0", k, got_p1[k]); else n_pass++;
    end
    step();
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_p1[k] !== 1'b1) $display("FAIL pend_set cfg%0d got=%b exp=1", k, got_p1[k]); else n_pass++;
    end
    drive(1'b1, 1'b1, 1'b0, 4'd3, 4'd1, 4'd3, 16'h0011, 4'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_p1[k] !== 1'b0) $display("FAIL pend_clear cfg%0d got=%b exp=0", k, got_p1[k]); else n_pass++;
    end
    drive(1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 16'h0022, 4'd3);
    step();
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_p1[k] !== 1'b1) $display("FAIL pend_set_wins cfg%0d got=%b exp=1", k, got_p1[k]); else n_pass++;
      n_chk++; if (got_rd2[k] !== 16'h0022) $display("FAIL pend_write_rd2 cfg%0d got=%h exp=0022", k, got_rd2[k]); else n_pass++;
    end
    drive(1'b1, 1'b0, 1'b0, 4'd3, 4'd3, 4'd0, 16'h0, 4'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_rd1[k] !== 16'h0022) $display("FAIL pend_write_rd1 cfg%0d got=%h exp=0022", k, got_rd1[k]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_cycle();
    logic [15:0] e [3];
    drive(1'b1, 1'b1, 1'b0, 4'd15, 4'd1, 4'd15, 16'hBEEF, 4'd0);
    step();
    e = '{16'h00EF, 16'h0000, 16'hBEEF};
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_rd1[k] !== e[k]) $display("FAIL r15_rd1 cfg%0d got=%h exp=%h", k, got_rd1[k], e[k]); else n_pass++;
      n_chk++; if (got_ded[k] !== e[k]) $display("FAIL r15_ded cfg%0d got=%h exp=%h", k, got_ded[k], e[k]); else n_pass++;
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_rd1[k] !== 16'h0) $display("FAIL async_rd1 cfg%0d got=%h exp=0000", k, got_rd1[k]); else n_pass++;
      n_chk++; if (got_ded[k] !== 16'h0) $display("FAIL async_ded cfg%0d got=%h exp=0000", k, got_ded[k]); else n_pass++;
    end
    drive(1'b1, 1'b1, 1'b1, 4'd15, 4'd1, 4'd15, 16'h1234, 4'd15);
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'd15, 4'd1, 4'd0, 16'h0, 4'd0);
    step();
    e = '{16'h0000, 16'h005A, 16'h0000};
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (got_rd1[k] !== 16'h0) $display("FAIL released_rd1 cfg%0d got=%h exp=0000", k, got_rd1[k]); else n_pass++;
      n_chk++; if (got_rd2[k] !== e[k]) $display("FAIL released_rd2 cfg%0d got=%h exp=%h", k, got_rd2[k], e[k]); else n_pass++;
      n_chk++; if (got_p1[k] !== 1'b0) $display("FAIL released_pend cfg%0d got=%b exp=0", k, got_p1[k]); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            16'($urandom), 4'($urandom_range(0, 15)));
      step();
      for (int k = 0; k < 3; k++) begin
        bit ep1, ep2;
        ep1 = valid(k, amask(k, s_ra1)) ? m_pend[k][amask(k, s_ra1)] : 1'b0;
        ep2 = valid(k, amask(k, s_ra2)) ? m_pend[k][amask(k, s_ra2)] : 1'b0;
        n_chk++; if (got_rd1[k] !== m_rd1[k]) $display("FAIL rand_rd1 cfg%0d cyc%0d got=%h exp=%h", k, n, got_rd1[k], m_rd1[k]); else n_pass++;
        n_chk++; if (got_rd2[k] !== m_rd2[k]) $display("FAIL rand_rd2 cfg%0d cyc%0d got=%h exp=%h", k, n, got_rd2[k], m_rd2[k]); else n_pass++;
        n_chk++; if (got_ded[k] !== m_ded[k]) $display("FAIL rand_ded cfg%0d cyc%0d got=%h exp=%h", k, n, got_ded[k], m_ded[k]); else n_pass++;
        n_chk++; if (got_p1[k] !== ep1) $display("FAIL rand_pend1 cfg%0d cyc%0d got=%b exp=%b", k, n, got_p1[k], ep1); else n_pass++;
        n_chk++; if (got_p2[k] !== ep2) $display("FAIL rand_pend2 cfg%0d cyc%0d got=%b exp=%b", k, n, got_p2[k], ep2); else n_pass++;
      end
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0, 4'd0);
    model_reset();
    test_reset();
    test_bypass();
    test_dedicated_hold();
    test_zero_reg();
    test_pending();
    test_reset_mid_cycle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
